// File: rtl/vga_tile_fetch_arbiter_pkg.sv
// Shared constants and FSM encoding for the display-memory arbiter.
package vga_tile_fetch_arbiter_pkg;

    localparam int unsigned H_TOTAL_DEFAULT = 800;
    localparam int unsigned V_TOTAL_DEFAULT = 525;
    localparam int unsigned REGION          = 128;
    localparam int unsigned ADDR_W          = 9;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned COORD_W         = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VGA_CAP = 2'd1,
        ST_CPU_CAP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vga_prefetch_addr.sv
// Prefetch target: pixel five columns ahead, wrapped across line and frame,
// tested against the bitmap region and packed into a tile word address.
module vga_prefetch_addr
    import vga_tile_fetch_arbiter_pkg::*;
#(
    parameter int unsigned H_TOTAL = H_TOTAL_DEFAULT,
    parameter int unsigned V_TOTAL = V_TOTAL_DEFAULT
) (
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    output logic [ADDR_W-1:0]  fetch_addr_c,
    output logic               in_region_c
);

    localparam int unsigned LEAD  = 5;
    localparam int unsigned EXT_W = COORD_W + 1;

    logic [EXT_W-1:0] p_raw;
    logic [EXT_W-1:0] p;
    logic [EXT_W-1:0] py_inc;
    logic [EXT_W-1:0] py;

    always_comb begin
        p_raw  = EXT_W'(pixel_x) + EXT_W'(LEAD);
        py_inc = EXT_W'(pixel_y) + EXT_W'(1);
        p      = p_raw;
        py     = EXT_W'(pixel_y);
        if (p_raw >= EXT_W'(H_TOTAL)) begin
            p  = p_raw - EXT_W'(H_TOTAL);
            py = (py_inc >= EXT_W'(V_TOTAL)) ? '0 : py_inc;
        end
        in_region_c  = (p < EXT_W'(REGION)) && (py < EXT_W'(REGION));
        fetch_addr_c = {py[6:3], p[6:2]};
    end

endmodule

// File: rtl/vga_tile_fetch_arbiter.sv
// Arbitrates the single-port display memory between tile prefetch (priority)
// and CPU accesses; presents a stable tile word to the renderer.
module vga_tile_fetch_arbiter
    import vga_tile_fetch_arbiter_pkg::*;
#(
    parameter int unsigned H_TOTAL = H_TOTAL_DEFAULT,
    parameter int unsigned V_TOTAL = V_TOTAL_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_tick,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    output logic [DATA_W-1:0]  tile_data,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_ack,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [DATA_W-1:0]   next_word;
    logic [DATA_W-1:0]   rdata_q;
    logic                vga_pend;
    logic [ADDR_W-1:0]   vga_addr;
    logic                swap_c;
    logic [ADDR_W-1:0]   fetch_addr_c;
    logic                in_region_c;

    vga_prefetch_addr #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_prefetch_addr (
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .fetch_addr_c (fetch_addr_c),
        .in_region_c  (in_region_c)
    );

    assign swap_c    = pix_tick && (pixel_x[1:0] == 2'd3);
    assign mem_wdata = cpu_wdata;
    assign cpu_rdata = (state == ST_CPU_CAP) ? mem_rdata : rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue cycle drives the address; the following CAP state consumes mem_rdata.
    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_we    = 1'b0;
        cpu_ack   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (vga_pend) begin
                    mem_addr  = vga_addr;
                    state_nxt = ST_VGA_CAP;
                end else if (cpu_req && !rst) begin
                    mem_addr  = cpu_addr;
                    mem_we    = cpu_we;
                    state_nxt = ST_CPU_CAP;
                end
            end
            ST_VGA_CAP: begin
                if (cpu_req) begin
                    mem_addr  = cpu_addr;
                    mem_we    = cpu_we;
                    state_nxt = ST_CPU_CAP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CPU_CAP: begin
                cpu_ack = 1'b1;
                if (vga_pend) begin
                    mem_addr  = vga_addr;
                    state_nxt = ST_VGA_CAP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A swap never coincides with a VGA capture; if it did, the swap's update wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_data <= '0;
            next_word <= '0;
            vga_pend  <= 1'b0;
            vga_addr  <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == ST_CPU_CAP) begin
                rdata_q <= mem_rdata;
            end
            if (state == ST_VGA_CAP) begin
                next_word <= mem_rdata;
                vga_pend  <= 1'b0;
            end
            if (swap_c) begin
                tile_data <= next_word;
                if (in_region_c) begin
                    vga_addr <= fetch_addr_c;
                    vga_pend <= 1'b1;
                end else begin
                    next_word <= '0;
                end
            end
        end
    end

endmodule

// File: doc/vga_tile_fetch_arbiter.md
Name: vga_tile_fetch_arbiter

Overview:
Shares the single-port 512x32 display memory between the CPU data bus and the 128x128 monochrome bitmap renderer. Each 32-bit word is one 4-wide x 8-tall tile: nibble by pixel_y[2:0] (row 0 = bits 31:28), bit by pixel_x[1:0] (col 0 = MSB of the nibble). The block prefetches the next tile word ahead of the raster and presents a stable tile_data word to the pixel renderer. CPU accesses use the remaining memory cycles.

Parameters:
H_TOTAL, 800, pixels per line incl. blanking (multiple of 4)
V_TOTAL, 525, lines per frame incl. blanking

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
pix_tick  in  1  one-clk strobe per pixel; spacing >= 2 clk
pixel_x  in  10  column currently displayed (valid on pix_tick)
pixel_y  in  10  line currently displayed
tile_data  out  32  tile word for the current pixel, to the renderer
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  9  word address
cpu_wdata  in  32  write data
cpu_ack  out  1  one-clk completion pulse
cpu_rdata  out  32  read data, valid when cpu_ack=1
mem_addr  out  9  display memory address
mem_we  out  1  display memory write enable
mem_wdata  out  32  equals cpu_wdata
mem_rdata  in  32  registered read data, 1-clk latency

Behaviour:
- Word address for tile (x,y) = {y[6:3], x[6:2]}. The in-region test is x<128 and y<128.
- Registers: tile_data (current tile), next_word (prefetched tile), vga_pend, vga_addr, FSM state.
- Swap: a swap occurs on a clk with pix_tick=1 and pixel_x[1:0]=3.
  - tile_data <= next_word.
  - Prefetch target p = pixel_x+5. If p >= H_TOTAL: p -= H_TOTAL and py = pixel_y+1 (wraps to 0 at V_TOTAL); else py = pixel_y.
  - Target in region: vga_addr <= addr(p,py), vga_pend <= 1.
  - Target out of region: next_word <= 0, no memory cycle.
- FSM states: IDLE, VGA_CAP, CPU_CAP. mem_addr and mem_we are combinational from state; mem_we=0 unless a CPU write is being issued.
  - IDLE:
    - vga_pend set: drive vga_addr -> VGA_CAP (VGA has priority).
    - Else cpu_req set: drive cpu_addr, mem_we=cpu_we -> CPU_CAP.
    - Else stay in IDLE.
  - VGA_CAP: next_word <= mem_rdata and vga_pend <= 0. If cpu_req, issue the CPU access now -> CPU_CAP; else -> IDLE.
  - CPU_CAP: cpu_ack=1 and cpu_rdata=mem_rdata (writes also ack here). cpu_req is ignored this clk. If vga_pend, issue VGA -> VGA_CAP; else -> IDLE.
- CPU latency: ack 1 clk after issue. Worst case is 2 clks after the request under contention.
- Deadline: a prefetch completes <= 3 clks after the swap. Consecutive swaps are >= 8 clks apart, so a VGA capture never coincides with a swap.
- A swap while vga_pend=1 cannot occur. If the precondition is violated, the newer vga_addr overwrites the older one.
- cpu_rdata holds its last value outside ack.
- Reset (asynchronous, any state, including mid-transaction): state=IDLE, tile_data=0, next_word=0, vga_pend=0, cpu_ack=0, cpu_rdata=0, mem_we=0, mem_addr=0. An in-flight CPU access is dropped without ack and the requester re-issues it. The first two tiles after reset display 0.

Decomposition:
- Shared package: FSM state encodings, H_TOTAL/V_TOTAL defaults, the 128-pixel region size, the 9-bit address width.
- One natural sub-module, vga_prefetch_addr: combinational p/py wrap, region test and address pack. It is separately testable.

Test Plan:
1. Reset mid-transaction:
   - Stimulus: cpu_req=1 write; assert rst in the CPU_CAP clk.
   - Required: cpu_ack=0 immediately, tile_data=0, mem_we=0, state IDLE.
2. CPU write then read:
   - Stimulus: write 32'hDEADBEEF to 9'h021, then read 9'h021.
   - Required: each cpu_ack is 1 clk after issue; the read returns cpu_rdata=32'hDEADBEEF.
3. Prefetch pipeline:
   - Stimulus: memory word[i]=i; swap at pixel_x=7, pixel_y=8.
   - Required: mem_addr=9'h023 in the next clk; next_word=32'h23.
   - Required: at the swap with pixel_x=11, tile_data=32'h23.
4. Wrap and region:
   - Stimulus: swap at (795,9); swap at (799,127); swap at (795,524).
   - Required for (795,9): fetch addr 9'h020.
   - Required for (799,127): next_word=0 and no mem cycle.
   - Required for (795,524): fetch addr 9'h000.
5. Contention:
   - Stimulus: cpu_req read rises in the same clk that vga_pend is set.
   - Required: VGA address is issued first; CPU address is issued in VGA_CAP; cpu_ack 2 clks after the request.
6. Back-to-back CPU traffic:
   - Stimulus: cpu_req held continuously across a swap.
   - Required: the VGA fetch is inserted after the current CPU_CAP, and every prefetch still lands before the next swap.
